// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// in_ready and all out_* come straight from flops, so no combinational path crosses the stage.
module pipe_stage_buf #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mainData_q, mainData_d;
    logic [CTRL_W-1:0] mainCtrl_q, mainCtrl_d;
    logic [DATA_W-1:0] skidData_q, skidData_d;
    logic [CTRL_W-1:0] skidCtrl_q, skidCtrl_d;
    logic              inReady_q, inReady_d;

    logic inXfer;
    logic outXfer;

    assign inXfer  = in_valid & inReady_q;
    assign outXfer = (state_q != EMPTY) & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= EMPTY;
            mainData_q <= '0;
            mainCtrl_q <= '0;
            skidData_q <= '0;
            skidCtrl_q <= '0;
            inReady_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            mainData_q <= mainData_d;
            mainCtrl_q <= mainCtrl_d;
            skidData_q <= skidData_d;
            skidCtrl_q <= skidCtrl_d;
            inReady_q  <= inReady_d;
        end
    end

    // Flush overrides every handshake; a word accepted on the flush edge is simply never stored.
    always_comb begin
        state_d    = state_q;
        mainData_d = mainData_q;
        mainCtrl_d = mainCtrl_q;
        skidData_d = skidData_q;
        skidCtrl_d = skidCtrl_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (inXfer) begin
                        state_d    = ONE;
                        mainData_d = in_data;
                        mainCtrl_d = in_ctrl;
                    end
                end
                ONE: begin
                    if (inXfer && outXfer) begin
                        mainData_d = in_data;
                        mainCtrl_d = in_ctrl;
                    end else if (inXfer) begin
                        state_d    = TWO;
                        skidData_d = in_data;
                        skidCtrl_d = in_ctrl;
                    end else if (outXfer) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (outXfer) begin
                        state_d    = ONE;
                        mainData_d = skidData_q;
                        mainCtrl_d = skidCtrl_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        inReady_d = (state_d != TWO);
    end

    // Outputs decode registered state only; ctrl is zeroed into a bubble when nothing is held.
    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign out_valid = (state_q != EMPTY);
    assign out_data  = mainData_q;
    assign out_ctrl  = out_valid ? mainCtrl_q : '0;
    assign in_ready  = inReady_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomised and directed bench for pipe_stage_buf, checked against a queue-based model.
module tb_pipe_stage_buf;

    localparam int DATA_W = 16;
    localparam int CTRL_W = 8;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              flush;
    logic [1:0]        occupancy;

    pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .flush     (flush),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } entry_t;

    // The model is a FIFO of at most two words plus the last head value seen.
    entry_t            modelQ[$];
    logic              modelReady;
    logic [DATA_W-1:0] lastMain;
    int                testCount;
    int                failCount;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelReady = 1'b0;
        lastMain   = '0;
    endtask

    task automatic modelEdge();
        entry_t e;
        bit inX;
        bit outX;
        inX  = in_valid && modelReady;
        outX = (modelQ.size() > 0) && out_ready;
        if (modelQ.size() > 0) lastMain = modelQ[0].d;
        if (flush) begin
            modelQ.delete();
        end else begin
            if (outX) e = modelQ.pop_front();
            if (inX) begin
                e.d = in_data;
                e.c = in_ctrl;
                modelQ.push_back(e);
            end
        end
        if (modelQ.size() > 0) lastMain = modelQ[0].d;
        modelReady = (modelQ.size() < 2);
    endtask

    task automatic checkAll();
        bit               v;
        logic [DATA_W-1:0] expData;
        logic [CTRL_W-1:0] expCtrl;
        v       = modelQ.size() > 0;
        expData = v ? modelQ[0].d : lastMain;
        expCtrl = v ? modelQ[0].c : '0;
        checkOutput("out_valid", 32'(out_valid), 32'(v));
        checkOutput("out_data",  32'(out_data),  32'(expData));
        checkOutput("out_ctrl",  32'(out_ctrl),  32'(expCtrl));
        checkOutput("in_ready",  32'(in_ready),  32'(modelReady));
        checkOutput("occupancy", 32'(occupancy), 32'(modelQ.size()));
    endtask

    // One clock cycle: drive inputs, step the model at the edge, check on the falling edge.
    task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        if (rst) modelEdge();
        @(negedge clk);
        checkAll();
    endtask

    initial begin
        testCount = 0;
        failCount = 0;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        in_ctrl   = 8'h5A;
        out_ready = 1'b1;
        flush     = 1'b0;
        rst       = 1'b0;
        modelReset();

        // Reset held for three cycles with input offered.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'h1234, 8'h5A, 1'b1, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 16'h0BAD, 8'h11, 1'b1, 1'b0);
        checkOutput("first_edge_no_accept", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 16'h0C0D, 8'h22, 1'b1, 1'b0);
        checkOutput("first_word", 32'(out_data), 32'h0C0D);

        // Back-to-back streaming.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 16'(i), 8'($urandom), 1'b1, 1'b0);
            checkOutput("stream_occ", 32'(occupancy), 32'd1);
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

        // One-cycle stall fills the skid entry.
        applyStimulus(1'b1, 16'hA000, 8'h01, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'hA001, 8'h02, 1'b0, 1'b0);
        checkOutput("skid_occ", 32'(occupancy), 32'd2);
        applyStimulus(1'b1, 16'hA002, 8'h03, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'hA003, 8'h04, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

        // Long stall then drain.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'hB000 + 16'(i), 8'h30 + 8'(i), 1'b0, 1'b0);
        checkOutput("stall_data", 32'(out_data), 32'hB000);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush while full, with a word offered on the same edge.
        applyStimulus(1'b1, 16'hC000, 8'hFF, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hC001, 8'hFF, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hBEEF, 8'hFF, 1'b1, 1'b1);
        checkOutput("flush_ctrl", 32'(out_ctrl), 32'h00);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            applyStimulus(1'($urandom_range(0, 3) != 0), 16'($urandom), 8'($urandom),
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));

        // Asynchronous reset while holding two words.
        applyStimulus(1'b1, 16'hD000, 8'h77, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hD001, 8'h78, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hD002, 8'h79, 1'b0, 1'b0);
        checkOutput("pre_reset_occ", 32'(occupancy), 32'd2);
        #2 rst = 1'b0;
        #1;
        modelReset();
        checkAll();
        applyStimulus(1'b1, 16'h1111, 8'h11, 1'b1, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'hE000 + 16'(i), 8'h40 + 8'(i), 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and bubble masking of control fields. It replaces the fixed-field, always-enabled stage registers between EX, MEM and WB: a stage can stall, be flushed, or absorb one extra word without a combinational ready path crossing the stage. Instances sit at every inter-stage boundary of the pipelined RISC core, one per boundary, with payload and control widths set per stage.

## Interface
Parameters:
- DATA_W, 16, payload width (ALU result, store data, etc.); carried unchanged.
- CTRL_W, 8, control-field width (reg write enable, mem enable, mem write, halt, dest reg, ...); forced to zero on out_ctrl whenever out_valid=0.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream word present.
- in_ready  out  1  stage can accept; registered output.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control field.
- out_valid  out  1  stage holds a valid word.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  payload of head entry.
- out_ctrl  out  CTRL_W  control of head entry, zero when out_valid=0.
- flush  in  1  synchronous kill of all held entries.
- occupancy  out  2  entries held: 0, 1 or 2.

## Operation
- Input transfer: in_valid & in_ready at a rising edge. Output transfer: out_valid & out_ready.
- Storage: main entry (drives outputs) and skid entry, each {data, ctrl}.
- States: EMPTY (occupancy 0), ONE (main full), TWO (main and skid full).
- EMPTY: input transfer -> ONE, main <= input.
- ONE: input and output transfer -> ONE, main <= input; input only -> TWO, skid <= input; output only -> EMPTY; neither -> ONE, hold.
- TWO: no input accepted (in_ready=0); output transfer -> ONE, main <= skid; otherwise hold.
- Order preserved strictly; no word duplicated or dropped except by flush.
- flush=1: next state EMPTY regardless of handshakes; any simultaneous input transfer is discarded; a simultaneous output transfer still completes downstream this cycle (downstream samples before edge).
- out_valid = (state != EMPTY); out_data = main data; out_ctrl = main ctrl when valid, else all zero (bubble: no register write, no memory access, no halt).
- out_data not masked; holds last main value when invalid.
- in_ready flop: next value = 1 unless next state is TWO.

## Timing
- Reset (rst low, asynchronous): state EMPTY, occupancy 0, out_valid 0, out_ctrl 0, out_data 0, main/skid contents 0, in_ready 0.
- First rising edge after rst release: in_ready goes 1; no input accepted on that edge.
- Latency: word accepted at edge N appears on outputs (out_valid=1) after edge N when EMPTY or consumed same edge; one cycle.
- Throughput: one word per cycle while out_ready=1 continuously.
- in_ready depends only on flops; no combinational path from out_ready to in_ready. out_* depend only on flops.
- Backpressure: out_ready low for one cycle with continuous input fills skid; in_ready drops on the following edge, never losing the word offered during the stall cycle.
- Flush asserted while TWO: EMPTY and in_ready=1 after the edge.
- Flush and rst both asserted: rst dominates.

## Test plan
- Reset: hold rst low 3 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, in_ready=0, occupancy=0; in_ready=1 one edge after release, first word accepted next edge.
- Streaming: DATA_W=16, send 0x0001..0x0010 back-to-back with out_ready=1 -> same 16 words out in order, one per cycle, each 1 cycle after acceptance, occupancy stays 1.
- Skid: stream 0xA000, 0xA001, 0xA002 with out_ready low for one cycle at 0xA001 -> occupancy 2, in_ready 0 for one cycle, output sequence A000, A001, A002 unbroken, nothing lost.
- Full stall: out_ready low 5 cycles, in_valid high -> exactly 2 words held, in_ready=0, out_data stable; release -> drains in order.
- Flush: in TWO with ctrl=0xFF entries, assert flush with in_valid=1 data 0xBEEF -> next cycle occupancy 0, out_valid 0, out_ctrl 0x00; 0xBEEF never appears at output.
- Async reset mid-stream: drop rst between edges while occupancy=2 -> outputs reach reset values immediately without a clock edge.
